kernel_sched: RTL and testbench

Sequencer for the 3x3 convolution kernel datapath. For every pixel of an IMG_W x IMG_H frame, it steps the kernel weight mux through the nine tap positions in raster order, one tap per cycle. It generates the pixel/tap coordinates for the line-buffer address logic and the clear/enable strobes for the downstream MAC. Out-of-image taps are zero-padded: the select code is driven to 0000, so the mux outputs a zero weight, and accumulation is suppressed.

---
 rtl/kernel_pkg.sv | 37 +++
 rtl/kernel_tap_lut.sv | 35 +++
 rtl/kernel_sched.sv | 142 ++++++++++++++
 tb/tb_kernel_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_pkg.sv
// kernel_pkg: shared definitions for the 3x3 convolution kernel sequencer.
//   - 4-bit tap codes driven to the kernel weight mux (CODE_ZERO = padded tap)
//   - NTAPS: taps per pixel
//   - state_t: sequencer FSM states
//   - tap_idx_t: tap index (0..8), offset_t: signed 2-bit tap offset
package kernel_pkg;

    localparam int NTAPS = 9;

    typedef logic [3:0] tap_idx_t;
    typedef logic [3:0] tap_code_t;
    typedef logic signed [1:0] offset_t;

    localparam tap_idx_t LAST_TAP = tap_idx_t'(NTAPS - 1);

    localparam tap_code_t CODE_TL   = 4'b0001;
    localparam tap_code_t CODE_T    = 4'b0111;
    localparam tap_code_t CODE_TR   = 4'b0010;
    localparam tap_code_t CODE_L    = 4'b0110;
    localparam tap_code_t CODE_C    = 4'b1111;
    localparam tap_code_t CODE_R    = 4'b0101;
    localparam tap_code_t CODE_BL   = 4'b0011;
    localparam tap_code_t CODE_B    = 4'b1000;
    localparam tap_code_t CODE_BR   = 4'b0100;
    localparam tap_code_t CODE_ZERO = 4'b0000;

    localparam offset_t OFF_NEG  = 2'b11;
    localparam offset_t OFF_ZERO = 2'b00;
    localparam offset_t OFF_POS  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/kernel_tap_lut.sv
// kernel_tap_lut: combinational map from tap index to weight-mux code and
// nominal (dx, dy) offset, raster order tl, t, tr, l, c, r, bl, b, br.
// Ports:
//   tap_idx  in   tap index 0..8 (out-of-range indices give code 0, offset 0)
//   code     out  4-bit weight mux code
//   dx       out  signed column offset (-1/0/+1)
//   dy       out  signed row offset (-1/0/+1)
module kernel_tap_lut
    import kernel_pkg::*;
(
    input  tap_idx_t  tap_idx,
    output tap_code_t code,
    output offset_t   dx,
    output offset_t   dy
);

    always_comb begin
        code = CODE_ZERO;
        dx   = OFF_ZERO;
        dy   = OFF_ZERO;
        case (tap_idx)
            4'd0: begin code = CODE_TL; dx = OFF_NEG;  dy = OFF_NEG;  end
            4'd1: begin code = CODE_T;  dx = OFF_ZERO; dy = OFF_NEG;  end
            4'd2: begin code = CODE_TR; dx = OFF_POS;  dy = OFF_NEG;  end
            4'd3: begin code = CODE_L;  dx = OFF_NEG;  dy = OFF_ZERO; end
            4'd4: begin code = CODE_C;  dx = OFF_ZERO; dy = OFF_ZERO; end
            4'd5: begin code = CODE_R;  dx = OFF_POS;  dy = OFF_ZERO; end
            4'd6: begin code = CODE_BL; dx = OFF_NEG;  dy = OFF_POS;  end
            4'd7: begin code = CODE_B;  dx = OFF_ZERO; dy = OFF_POS;  end
            4'd8: begin code = CODE_BR; dx = OFF_POS;  dy = OFF_POS;  end
            default: ;
        endcase
    end

endmodule

// File: rtl/kernel_sched.sv
// kernel_sched: sequencer for the 3x3 convolution datapath. Steps nine taps
// per pixel in raster order over an IMG_W x IMG_H frame, zero-pads taps that
// fall outside the image and produces the MAC clear/enable/done strobes.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   start        frame request, only honoured in IDLE
//   stall        freezes sequencing; strobes forced low while high
//   select       weight mux code (0000 for padded taps and outside RUN)
//   pix_x/pix_y  current output pixel coordinate
//   tap_dx/dy    nominal signed offset of the current tap (0 outside RUN)
//   tap_valid    current tap lies inside the image
//   acc_clr      first tap of a pixel
//   acc_en       accumulate current product
//   pix_done     last tap of a pixel
//   frame_done   one-cycle pulse after the final tap of the frame
//   busy         high in RUN and DONE
module kernel_sched
    import kernel_pkg::*;
#(
    parameter int  IMG_W = 8,
    parameter int  IMG_H = 8,
    localparam int XW    = $clog2(IMG_W),
    localparam int YW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    output logic [0:3]    select,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [1:0]    tap_dx,
    output logic [1:0]    tap_dy,
    output logic          tap_valid,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          pix_done,
    output logic          frame_done,
    output logic          busy
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    state_t        state_reg, state_next;
    tap_idx_t      tap_reg, tap_next;
    logic [XW-1:0] x_reg, x_next;
    logic [YW-1:0] y_reg, y_next;

    tap_code_t lut_code;
    offset_t   lut_dx;
    offset_t   lut_dy;
    logic      in_bounds;
    logic      run;
    logic      strobe_ok;

    kernel_tap_lut u_lut (
        .tap_idx (tap_reg),
        .code    (lut_code),
        .dx      (lut_dx),
        .dy      (lut_dy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            tap_reg   <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            tap_reg   <= tap_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
        end
    end

    // Next-state and counter advance. The counters wrap back to zero on the
    // final tap of the frame, so they are already cleared when DONE/IDLE.
    always_comb begin
        state_next = state_reg;
        tap_next   = tap_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    tap_next   = '0;
                    x_next     = '0;
                    y_next     = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (tap_reg == LAST_TAP) begin
                        tap_next = '0;
                        if (x_reg == X_LAST) begin
                            x_next = '0;
                            if (y_reg == Y_LAST) begin
                                y_next     = '0;
                                state_next = DONE;
                            end else begin
                                y_next = y_reg + YW'(1);
                            end
                        end else begin
                            x_next = x_reg + XW'(1);
                        end
                    end else begin
                        tap_next = tap_reg + tap_idx_t'(1);
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: tap information only exists in RUN; strobes additionally
    // drop while stalled so a held tap is never accumulated twice.
    always_comb begin
        run       = (state_reg == RUN);
        strobe_ok = run && !stall;
        in_bounds = !((lut_dx == OFF_NEG) && (x_reg == '0))
                 && !((lut_dx == OFF_POS) && (x_reg == X_LAST))
                 && !((lut_dy == OFF_NEG) && (y_reg == '0))
                 && !((lut_dy == OFF_POS) && (y_reg == Y_LAST));

        tap_valid  = run && in_bounds;
        select     = tap_valid ? lut_code : CODE_ZERO;
        tap_dx     = run ? lut_dx : OFF_ZERO;
        tap_dy     = run ? lut_dy : OFF_ZERO;
        pix_x      = x_reg;
        pix_y      = y_reg;
        acc_clr    = strobe_ok && (tap_reg == '0);
        acc_en     = strobe_ok && in_bounds;
        pix_done   = strobe_ok && (tap_reg == LAST_TAP);
        frame_done = (state_reg == DONE);
        busy       = (state_reg != IDLE);
    end

endmodule

// File: tb/tb_kernel_sched.sv
// tb_kernel_sched: directed self-checking bench for kernel_sched on a 3x3
// frame. Inputs are driven and outputs sampled on the falling clock edge.
module tb_kernel_sched;

    localparam int W  = 3;
    localparam int H  = 3;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int MAX_WAIT = 300;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stall;
    logic [0:3]    select;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [1:0]    tap_dx;
    logic [1:0]    tap_dy;
    logic          tap_valid;
    logic          acc_clr;
    logic          acc_en;
    logic          pix_done;
    logic          frame_done;
    logic          busy;

    int tests_run = 0;
    int tests_failed = 0;

    kernel_sched #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stall      (stall),
        .select     (select),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .tap_dx     (tap_dx),
        .tap_dy     (tap_dy),
        .tap_valid  (tap_valid),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .pix_done   (pix_done),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock: passes exactly one rising edge, returns on the
    // following falling edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Pulse start for one cycle; returns with tap 0 of pixel (0,0) showing.
    task automatic start_frame();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        #1;
    endtask

    // Run until frame_done shows (bounded), count cycles spent before it,
    // then step past the DONE cycle.
    task automatic drain(output int cycles);
        cycles = 0;
        while (!frame_done && cycles < MAX_WAIT) begin
            next_cycle();
            #1;
            cycles++;
        end
        tests_run++;
        if (!frame_done) begin
            tests_failed++;
            $display("FAIL drain_timeout: frame_done not seen after %0d cycles", cycles);
        end
        next_cycle();
        #1;
    endtask

    task automatic test_reset();
        int dummy;
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        next_cycle();
        #1;
        tests_run++;
        if ({select, pix_x, pix_y, tap_dx, tap_dy, tap_valid, acc_clr, acc_en,
             pix_done, frame_done, busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got sel=%b x=%0d y=%0d dx=%b dy=%b v=%b clr=%b en=%b pd=%b fd=%b busy=%b, want all 0",
                     select, pix_x, pix_y, tap_dx, tap_dy, tap_valid, acc_clr, acc_en, pix_done, frame_done, busy);
        end
        rst_n = 1'b1;
        next_cycle();
        start_frame();
        for (int i = 0; i < 12; i++) next_cycle();
        #1;
        // Cycle 12 from tap 0 is pixel (1,0) tap 3.
        tests_run++;
        if (busy !== 1'b1 || pix_x !== XW'(1)) begin
            tests_failed++;
            $display("FAIL reset_prerun: got busy=%b x=%0d, want busy=1 x=1", busy, pix_x);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({select, pix_x, pix_y, tap_dx, tap_dy, tap_valid, acc_clr, acc_en,
             pix_done, frame_done, busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_midrun: got sel=%b x=%0d y=%0d dx=%b dy=%b v=%b clr=%b en=%b pd=%b fd=%b busy=%b, want all 0",
                     select, pix_x, pix_y, tap_dx, tap_dy, tap_valid, acc_clr, acc_en, pix_done, frame_done, busy);
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        start_frame();
        tests_run++;
        if (busy !== 1'b1 || pix_x !== '0 || pix_y !== '0 || tap_dx !== 2'b11 ||
            tap_dy !== 2'b11 || acc_clr !== 1'b1 || select !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_restart: got busy=%b x=%0d y=%0d dx=%b dy=%b clr=%b sel=%b, want 1 0 0 11 11 1 0000",
                     busy, pix_x, pix_y, tap_dx, tap_dy, acc_clr, select);
        end
        drain(dummy);
        $display("[TB] test_reset done");
    endtask

    task automatic test_full_frame();
        logic [3:0] exp_centre [9];
        logic [3:0] got_centre [9];
        int run_cnt = 0;
        int pd_cnt = 0;
        int en_cnt = 0;
        int clr_cnt = 0;
        int ci = 0;
        exp_centre = '{4'b0001, 4'b0111, 4'b0010, 4'b0110, 4'b1111,
                       4'b0101, 4'b0011, 4'b1000, 4'b0100};
        for (int i = 0; i < 9; i++) got_centre[i] = 4'hx;
        start_frame();
        while (!frame_done && run_cnt < MAX_WAIT) begin
            run_cnt++;
            if (pix_done) pd_cnt++;
            if (acc_en) en_cnt++;
            if (acc_clr) clr_cnt++;
            if (pix_x == XW'(1) && pix_y == YW'(1) && ci < 9) begin
                got_centre[ci] = select;
                ci++;
            end
            next_cycle();
            #1;
        end
        tests_run++;
        if (run_cnt !== 81 || frame_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_len: got %0d RUN cycles fd=%b, want 81 fd=1", run_cnt, frame_done);
        end
        tests_run++;
        if (pd_cnt !== 9) begin
            tests_failed++;
            $display("FAIL pix_done_count: got %0d, want 9", pd_cnt);
        end
        tests_run++;
        if (en_cnt !== 49) begin
            tests_failed++;
            $display("FAIL acc_en_count: got %0d, want 49", en_cnt);
        end
        tests_run++;
        if (clr_cnt !== 9) begin
            tests_failed++;
            $display("FAIL acc_clr_count: got %0d, want 9", clr_cnt);
        end
        for (int i = 0; i < 9; i++) begin
            tests_run++;
            if (got_centre[i] !== exp_centre[i]) begin
                tests_failed++;
                $display("FAIL centre_tap%0d: got %b, want %b", i, got_centre[i], exp_centre[i]);
            end
        end
        next_cycle();
        #1;
        tests_run++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_done_pulse: got fd=%b busy=%b after DONE, want 0 0", frame_done, busy);
        end
        $display("[TB] test_full_frame: %0d RUN cycles, pix_done=%0d acc_en=%0d", run_cnt, pd_cnt, en_cnt);
    endtask

    task automatic test_corner();
        logic [3:0] exp_sel [9];
        int dummy;
        exp_sel = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111,
                    4'b0101, 4'b0000, 4'b1000, 4'b0100};
        start_frame();
        for (int t = 0; t < 9; t++) begin
            tests_run++;
            if (select !== exp_sel[t] || acc_en !== (exp_sel[t] != 4'b0000) ||
                acc_clr !== (t == 0) || pix_done !== (t == 8) ||
                pix_x !== '0 || pix_y !== '0) begin
                tests_failed++;
                $display("FAIL corner_tap%0d: got sel=%b en=%b clr=%b pd=%b x=%0d y=%0d, want sel=%b en=%b clr=%b pd=%b x=0 y=0",
                         t, select, acc_en, acc_clr, pix_done, pix_x, pix_y,
                         exp_sel[t], exp_sel[t] != 4'b0000, t == 0, t == 8);
            end
            next_cycle();
            #1;
        end
        drain(dummy);
        $display("[TB] test_corner done");
    endtask

    task automatic test_stall();
        int c = 0;
        int rest;
        start_frame();
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            c++;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            #1;
            tests_run++;
            if (select !== 4'b1111 || acc_en !== 1'b0 || acc_clr !== 1'b0 ||
                pix_done !== 1'b0 || pix_x !== XW'(1) || pix_y !== '0) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got sel=%b en=%b clr=%b pd=%b x=%0d y=%0d, want 1111 0 0 0 x=1 y=0",
                         i, select, acc_en, acc_clr, pix_done, pix_x, pix_y);
            end
            next_cycle();
            c++;
        end
        stall = 1'b0;
        #1;
        tests_run++;
        if (select !== 4'b1111 || acc_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release: got sel=%b en=%b, want 1111 1", select, acc_en);
        end
        next_cycle();
        c++;
        #1;
        tests_run++;
        if (select !== 4'b0101 || tap_dx !== 2'b01 || tap_dy !== 2'b00) begin
            tests_failed++;
            $display("FAIL stall_resume: got sel=%b dx=%b dy=%b, want 0101 01 00", select, tap_dx, tap_dy);
        end
        drain(rest);
        tests_run++;
        if (c + rest !== 84) begin
            tests_failed++;
            $display("FAIL stall_frame_len: got %0d RUN cycles, want 84", c + rest);
        end
        $display("[TB] test_stall: frame took %0d RUN cycles", c + rest);
    endtask

    task automatic test_start_busy();
        int c = 0;
        int fd_cnt = 0;
        start_frame();
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            c++;
        end
        // Cycle 20 is pixel (2,0) tap 2; the pulse must not restart the frame.
        start = 1'b1;
        next_cycle();
        c++;
        start = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b1 || pix_x !== XW'(2) || pix_y !== '0 || tap_dx !== 2'b11 || tap_dy !== 2'b00) begin
            tests_failed++;
            $display("FAIL busy_start_ignored: got busy=%b x=%0d y=%0d dx=%b dy=%b, want 1 2 0 11 00",
                     busy, pix_x, pix_y, tap_dx, tap_dy);
        end
        while (!frame_done && c < MAX_WAIT) begin
            next_cycle();
            #1;
            c++;
        end
        tests_run++;
        if (c !== 81) begin
            tests_failed++;
            $display("FAIL busy_frame_len: got %0d RUN cycles, want 81", c);
        end
        // Start during DONE is also ignored.
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (frame_done) fd_cnt++;
            next_cycle();
            start = 1'b0;
            #1;
        end
        tests_run++;
        if (fd_cnt !== 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_single_done: got %0d frame_done pulses busy=%b, want 1 0", fd_cnt, busy);
        end
        $display("[TB] test_start_busy: %0d frame_done pulses", fd_cnt);
    endtask

    task automatic test_back_to_back();
        int c;
        start_frame();
        c = 0;
        while (!frame_done && c < MAX_WAIT) begin
            next_cycle();
            #1;
            c++;
        end
        next_cycle();
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: got busy=%b after DONE, want 0", busy);
        end
        start_frame();
        tests_run++;
        if (busy !== 1'b1 || frame_done !== 1'b0 || acc_clr !== 1'b1 ||
            pix_x !== '0 || pix_y !== '0 || tap_dx !== 2'b11 || tap_dy !== 2'b11) begin
            tests_failed++;
            $display("FAIL b2b_first_tap: got busy=%b fd=%b clr=%b x=%0d y=%0d dx=%b dy=%b, want 1 0 1 0 0 11 11",
                     busy, frame_done, acc_clr, pix_x, pix_y, tap_dx, tap_dy);
        end
        drain(c);
        tests_run++;
        if (c !== 81) begin
            tests_failed++;
            $display("FAIL b2b_frame_len: got %0d RUN cycles, want 81", c);
        end
        $display("[TB] test_back_to_back: second frame %0d RUN cycles", c);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        test_reset();
        test_full_frame();
        test_corner();
        test_stall();
        test_start_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
